// File: rtl/syn_gpu_pkg.sv
// Shared types for the grapheme GPU shape engines: draw-job layout,
// coordinate widths and the line-engine FSM states.
package syn_gpu_pkg;

    localparam int X_W     = 10;
    localparam int Y_W     = 9;
    localparam int COLOR_W = 8;
    // Signed width for the Bresenham error terms: one bit for sign, one for 2*err.
    localparam int ARITH_W = ((X_W > Y_W) ? X_W : Y_W) + 2;

    typedef struct packed {
        logic [X_W-1:0]     x0;
        logic [Y_W-1:0]     y0;
        logic [X_W-1:0]     x1;
        logic [Y_W-1:0]     y1;
        logic [COLOR_W-1:0] color;
    } gpu_draw_job_t;

    typedef enum logic [1:0] {
        EU_IDLE,
        EU_SETUP,
        EU_DRAW,
        EU_DONE
    } euclid_state_e;

endpackage

// File: rtl/syn_gpu_euclid_step.sv
// One combinational Bresenham step: advances the current point and error term.
// Shared by the line engine and later shape engines.
module syn_gpu_euclid_step
    import syn_gpu_pkg::*;
#(
    parameter int CX_W = X_W,
    parameter int CY_W = Y_W,
    parameter int A_W  = ARITH_W
) (
    input  logic signed [A_W-1:0] err_i,
    input  logic signed [A_W-1:0] dx_i,
    input  logic signed [A_W-1:0] dy_i,
    input  logic                  sx_i,
    input  logic                  sy_i,
    input  logic [CX_W-1:0]       cur_x_i,
    input  logic [CY_W-1:0]       cur_y_i,
    output logic [CX_W-1:0]       nxt_x_o,
    output logic [CY_W-1:0]       nxt_y_o,
    output logic signed [A_W-1:0] nxt_err_o
);

    logic signed [A_W-1:0] e2;
    logic                  step_x;
    logic                  step_y;

    // sx_i/sy_i set means the coordinate counts up, clear means down.
    always_comb begin
        e2        = err_i <<< 1;
        step_x    = (e2 >= dy_i);
        step_y    = (e2 <= dx_i);
        nxt_x_o   = cur_x_i;
        nxt_y_o   = cur_y_i;
        nxt_err_o = err_i;
        if (step_x) begin
            nxt_x_o   = sx_i ? (cur_x_i + CX_W'(1)) : (cur_x_i - CX_W'(1));
            nxt_err_o = nxt_err_o + dy_i;
        end
        if (step_y) begin
            nxt_y_o   = sy_i ? (cur_y_i + CY_W'(1)) : (cur_y_i - CY_W'(1));
            nxt_err_o = nxt_err_o + dx_i;
        end
    end

endmodule

// File: rtl/syn_gpu_euclid.sv
// Line-draw engine: takes one line job, rasterises it with Bresenham and
// streams pixel writes over valid/ready, reporting busy and a done pulse.
module syn_gpu_euclid
    import syn_gpu_pkg::*;
#(
    parameter int P_X_W     = X_W,
    parameter int P_Y_W     = Y_W,
    parameter int P_COLOR_W = COLOR_W
) (
    input  logic                 clk_ir,
    input  logic                 rst_il,
    input  logic                 euclid_job_start,
    input  gpu_draw_job_t        euclid_job_data,
    output logic                 euclid_busy,
    output logic                 euclid_job_done,
    output logic                 pxl_wr_valid,
    input  logic                 pxl_wr_ready,
    output logic [P_X_W-1:0]     pxl_x,
    output logic [P_Y_W-1:0]     pxl_y,
    output logic [P_COLOR_W-1:0] pxl_color
);

    localparam int A_W = ARITH_W;

    euclid_state_e         state_q, state_d;
    gpu_draw_job_t         job_q, job_d;
    logic signed [A_W-1:0] dx_q, dx_d, dy_q, dy_d, err_q, err_d;
    logic                  sx_q, sx_d, sy_q, sy_d;
    logic [P_X_W-1:0]      cur_x_q, cur_x_d;
    logic [P_Y_W-1:0]      cur_y_q, cur_y_d;
    logic                  valid_q, valid_d, busy_q, busy_d, done_q, done_d;

    logic [P_X_W-1:0]      diff_x, step_x;
    logic [P_Y_W-1:0]      diff_y, step_y;
    logic signed [A_W-1:0] abs_dx, neg_dy, step_err;
    logic                  at_end;

    syn_gpu_euclid_step #(
        .CX_W (P_X_W),
        .CY_W (P_Y_W),
        .A_W  (A_W)
    ) u_step (
        .err_i     (err_q),
        .dx_i      (dx_q),
        .dy_i      (dy_q),
        .sx_i      (sx_q),
        .sy_i      (sy_q),
        .cur_x_i   (cur_x_q),
        .cur_y_i   (cur_y_q),
        .nxt_x_o   (step_x),
        .nxt_y_o   (step_y),
        .nxt_err_o (step_err)
    );

    always_comb begin
        diff_x = (job_q.x1 >= job_q.x0) ? (job_q.x1 - job_q.x0) : (job_q.x0 - job_q.x1);
        diff_y = (job_q.y1 >= job_q.y0) ? (job_q.y1 - job_q.y0) : (job_q.y0 - job_q.y1);
        abs_dx = $signed(A_W'(diff_x));
        neg_dy = -$signed(A_W'(diff_y));
        at_end = (cur_x_q == job_q.x1) && (cur_y_q == job_q.y1);
    end

    always_comb begin
        state_d = state_q;
        job_d   = job_q;
        dx_d    = dx_q;
        dy_d    = dy_q;
        err_d   = err_q;
        sx_d    = sx_q;
        sy_d    = sy_q;
        cur_x_d = cur_x_q;
        cur_y_d = cur_y_q;
        valid_d = valid_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        case (state_q)
            EU_IDLE: begin
                if (euclid_job_start) begin
                    job_d   = euclid_job_data;
                    busy_d  = 1'b1;
                    state_d = EU_SETUP;
                end
            end
            EU_SETUP: begin
                dx_d    = abs_dx;
                dy_d    = neg_dy;
                err_d   = abs_dx + neg_dy;
                sx_d    = (job_q.x0 < job_q.x1);
                sy_d    = (job_q.y0 < job_q.y1);
                cur_x_d = job_q.x0;
                cur_y_d = job_q.y0;
                valid_d = 1'b1;
                state_d = EU_DRAW;
            end
            EU_DRAW: begin
                if (valid_q && pxl_wr_ready) begin
                    if (at_end) begin
                        valid_d = 1'b0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = EU_DONE;
                    end else begin
                        cur_x_d = step_x;
                        cur_y_d = step_y;
                        err_d   = step_err;
                    end
                end
            end
            EU_DONE: begin
                state_d = EU_IDLE;
            end
            default: state_d = EU_IDLE;
        endcase
    end

    always_ff @(posedge clk_ir) begin
        if (rst_il) begin
            state_q <= EU_IDLE;
            job_q   <= '0;
            dx_q    <= '0;
            dy_q    <= '0;
            err_q   <= '0;
            sx_q    <= 1'b0;
            sy_q    <= 1'b0;
            cur_x_q <= '0;
            cur_y_q <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            job_q   <= job_d;
            dx_q    <= dx_d;
            dy_q    <= dy_d;
            err_q   <= err_d;
            sx_q    <= sx_d;
            sy_q    <= sy_d;
            cur_x_q <= cur_x_d;
            cur_y_q <= cur_y_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign euclid_busy     = busy_q;
    assign euclid_job_done = done_q;
    assign pxl_wr_valid    = valid_q;
    assign pxl_x           = cur_x_q;
    assign pxl_y           = cur_y_q;
    assign pxl_color       = job_q.color;

endmodule

// File: tb/tb_syn_gpu_euclid.sv
// Scoreboard bench for the line engine: stimulus pushes hand-computed pixels,
// a negedge monitor pops and compares every accepted pixel write.
module tb_syn_gpu_euclid;
    import syn_gpu_pkg::*;

    logic               clk_ir = 1'b0;
    logic               rst_il = 1'b1;
    logic               euclid_job_start = 1'b0;
    gpu_draw_job_t      euclid_job_data = '0;
    logic               euclid_busy;
    logic               euclid_job_done;
    logic               pxl_wr_valid;
    logic               pxl_wr_ready = 1'b0;
    logic [X_W-1:0]     pxl_x;
    logic [Y_W-1:0]     pxl_y;
    logic [COLOR_W-1:0] pxl_color;

    syn_gpu_euclid dut (
        .clk_ir           (clk_ir),
        .rst_il           (rst_il),
        .euclid_job_start (euclid_job_start),
        .euclid_job_data  (euclid_job_data),
        .euclid_busy      (euclid_busy),
        .euclid_job_done  (euclid_job_done),
        .pxl_wr_valid     (pxl_wr_valid),
        .pxl_wr_ready     (pxl_wr_ready),
        .pxl_x            (pxl_x),
        .pxl_y            (pxl_y),
        .pxl_color        (pxl_color)
    );

    always #5 clk_ir = ~clk_ir;

    typedef struct packed {
        logic [X_W-1:0]     x;
        logic [Y_W-1:0]     y;
        logic [COLOR_W-1:0] c;
    } pix_t;

    pix_t exp_q[$];
    int   checks   = 0;
    int   errors   = 0;
    int   done_cnt = 0;
    logic stall_prev = 1'b0;
    pix_t stall_pix  = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic push(input int x, input int y, input int c);
        exp_q.push_back('{x: X_W'(x), y: Y_W'(y), c: COLOR_W'(c)});
    endtask

    // Returns one cycle after the start pulse has been sampled.
    task automatic start_job(input int x0, input int y0, input int x1, input int y1, input int c);
        @(posedge clk_ir); #1;
        euclid_job_data  = '{x0: X_W'(x0), y0: Y_W'(y0), x1: X_W'(x1), y1: Y_W'(y1), color: COLOR_W'(c)};
        euclid_job_start = 1'b1;
        @(posedge clk_ir); #1;
        euclid_job_start = 1'b0;
    endtask

    task automatic wait_done(input int prev, input string name);
        int n = 0;
        while (done_cnt == prev && n < 300) begin
            @(posedge clk_ir);
            n++;
        end
        @(posedge clk_ir); #1;
        chk({name, "_done"}, done_cnt, prev + 1);
        chk({name, "_drained"}, exp_q.size(), 0);
    endtask

    // Monitor: compare every accepted pixel and check stalled outputs stay put.
    always @(negedge clk_ir) begin
        if (rst_il) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev)
                chk("stall_hold", {pxl_wr_valid, pxl_x, pxl_y, pxl_color}, {1'b1, stall_pix});
            if (euclid_job_done) done_cnt++;
            if (pxl_wr_valid && pxl_wr_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_pixel: got (%0d,%0d) expected none", pxl_x, pxl_y);
                end else begin
                    chk("pixel", {pxl_x, pxl_y, pxl_color}, exp_q.pop_front());
                end
            end
            stall_prev = pxl_wr_valid && !pxl_wr_ready;
            stall_pix  = '{x: pxl_x, y: pxl_y, c: pxl_color};
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int d0;
        repeat (3) @(posedge clk_ir);
        #1;
        chk("rst_outputs", {euclid_busy, euclid_job_done, pxl_wr_valid, pxl_x, pxl_y, pxl_color}, 0);
        chk("rst_state", 32'(dut.state_q), 32'(EU_IDLE));
        rst_il = 1'b0;

        // Horizontal line with full timing checks.
        pxl_wr_ready = 1'b1;
        push(0, 0, 8'h5A); push(1, 0, 8'h5A); push(2, 0, 8'h5A); push(3, 0, 8'h5A);
        d0 = done_cnt;
        start_job(0, 0, 3, 0, 8'h5A);
        chk("h_setup_valid", pxl_wr_valid, 0);
        chk("h_setup_busy", euclid_busy, 1);
        @(posedge clk_ir); #1;
        chk("h_first_valid", {pxl_wr_valid, pxl_x, pxl_y}, {1'b1, 10'd0, 9'd0});
        repeat (3) @(posedge clk_ir);
        #1;
        chk("h_last_px", {euclid_busy, pxl_wr_valid, pxl_x}, {1'b1, 1'b1, 10'd3});
        @(posedge clk_ir); #1;
        chk("h_done_cycle", {euclid_job_done, euclid_busy, pxl_wr_valid}, 3'b100);
        @(posedge clk_ir); #1;
        chk("h_done_pulse_end", euclid_job_done, 0);
        chk("h_done_cnt", done_cnt, d0 + 1);
        chk("h_drained", exp_q.size(), 0);

        // Steep line.
        push(0, 0, 8'h21); push(0, 1, 8'h21); push(1, 2, 8'h21);
        push(1, 3, 8'h21); push(2, 4, 8'h21); push(2, 5, 8'h21);
        d0 = done_cnt;
        start_job(0, 0, 2, 5, 8'h21);
        wait_done(d0, "steep");

        // Negative X direction.
        push(3, 2, 8'hC3); push(2, 2, 8'hC3); push(1, 2, 8'hC3); push(0, 2, 8'hC3);
        d0 = done_cnt;
        start_job(3, 2, 0, 2, 8'hC3);
        wait_done(d0, "neg");

        // Degenerate single-pixel job.
        push(5, 5, 8'h0F);
        d0 = done_cnt;
        start_job(5, 5, 5, 5, 8'h0F);
        wait_done(d0, "degen");

        // Backpressure: random ready with a forced 4-cycle stall mid-line.
        push(0, 0, 8'h99); push(1, 0, 8'h99); push(2, 1, 8'h99);
        push(3, 1, 8'h99); push(4, 2, 8'h99); push(5, 2, 8'h99);
        d0 = done_cnt;
        start_job(0, 0, 5, 2, 8'h99);
        for (int n = 0; n < 200 && done_cnt == d0; n++) begin
            pxl_wr_ready = (n >= 3 && n < 7) ? 1'b0 : 1'($urandom_range(0, 1));
            @(posedge clk_ir); #1;
        end
        pxl_wr_ready = 1'b1;
        wait_done(d0, "bp");

        // Start pulse during DRAW must be ignored.
        push(0, 0, 8'h11); push(1, 0, 8'h11); push(2, 0, 8'h11); push(3, 0, 8'h11);
        d0 = done_cnt;
        start_job(0, 0, 3, 0, 8'h11);
        @(posedge clk_ir); #1;
        euclid_job_data  = '{x0: 10'd7, y0: 9'd7, x1: 10'd8, y1: 9'd8, color: 8'hEE};
        euclid_job_start = 1'b1;
        @(posedge clk_ir); #1;
        euclid_job_start = 1'b0;
        wait_done(d0, "busy_start");
        repeat (5) @(posedge clk_ir);
        #1;
        chk("busy_start_one_done", done_cnt, d0 + 1);
        chk("busy_start_idle", {euclid_busy, pxl_wr_valid}, 2'b00);

        // Reset mid-line aborts the job.
        for (int i = 0; i < 10; i++) push(i, i, 8'h33);
        d0 = done_cnt;
        start_job(0, 0, 9, 9, 8'h33);
        repeat (4) @(posedge clk_ir);
        #1;
        chk("rst_mid_drawing", pxl_wr_valid, 1);
        rst_il = 1'b1;
        @(posedge clk_ir); #1;
        chk("rst_mid_outputs", {euclid_busy, euclid_job_done, pxl_wr_valid, pxl_x, pxl_y, pxl_color}, 0);
        chk("rst_mid_state", 32'(dut.state_q), 32'(EU_IDLE));
        rst_il = 1'b0;
        exp_q.delete();
        repeat (5) @(posedge clk_ir);
        #1;
        chk("rst_mid_no_done", done_cnt, d0);
        chk("rst_mid_quiet", pxl_wr_valid, 0);

        // Fresh job after reset.
        push(0, 0, 8'h77); push(0, 1, 8'h77); push(1, 2, 8'h77);
        push(1, 3, 8'h77); push(2, 4, 8'h77); push(2, 5, 8'h77);
        d0 = done_cnt;
        start_job(0, 0, 2, 5, 8'h77);
        wait_done(d0, "post_rst");

        repeat (3) @(posedge clk_ir);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
